cbus_arbiter: RTL and testbench

Shares the single memory-side cbus between NUM_REQ cache-side cbus masters (ICache on port 0, DCache on port 1 by default). Grants one requester at a time with round-robin fairness and holds the grant for a whole transaction, through the final beat of a burst. Sits between the L1 caches and the AXI bridge; requesters drive `creq` exactly as they would toward memory, unchanged.

---
 rtl/cbus_arbiter.sv | 129 ++++++++++++
 tb/tb_cbus_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cbus_arbiter.sv
// cbus_arbiter: shares one memory-side cbus among NUM_REQ cache-side masters.
// Round-robin grant, held for a whole transaction until the memory side
// returns ready&&last (or the owner aborts by dropping valid).
//
// Flattened bus layouts (LSB first):
//   cbus_req_t  (79 b): valid[0] is_write[1] size[4:2] addr[36:5]
//                       strobe[40:37] data[72:41] len[76:73] burst[78:77]
//   cbus_resp_t (34 b): ready[0] last[1] data[33:2]
// Requester i occupies ireqs[i*79 +: 79] and iresps[i*34 +: 34].
module cbus_arbiter #(
  parameter int  NUM_REQ = 2,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int REQ_W   = 79,
  localparam int RESP_W  = 34
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ*REQ_W-1:0]  ireqs,
  output logic [NUM_REQ*RESP_W-1:0] iresps,
  output logic [REQ_W-1:0]          oreq,
  input  logic [RESP_W-1:0]         oresp,
  output logic                      busy,
  output logic [IDX_W-1:0]          owner
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_q, rr_d;

  logic [REQ_W-1:0]   req_arr [NUM_REQ];
  logic [NUM_REQ-1:0] req_vld;
  logic [REQ_W-1:0]   own_req;
  logic               resp_ready;
  logic               resp_last;
  logic [IDX_W:0]     pick_res;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_win;

  // Split the flattened request bus into per-requester words and valids
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_split
    assign req_arr[i] = ireqs[i*REQ_W +: REQ_W];
    assign req_vld[i] = req_arr[i][0];
  end

  // First valid requester scanning from ptr upward (wrapping); returns {found, index}
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                             input logic [IDX_W-1:0]   ptr);
    logic             found;
    logic [IDX_W-1:0] win;
    int               idx;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && vld[idx]) begin
        found = 1'b1;
        win   = IDX_W'(idx);
      end
    end
    return {found, win};
  endfunction

  assign pick_res   = rr_pick(req_vld, rr_q);
  assign pick_found = pick_res[IDX_W];
  assign pick_win   = pick_res[IDX_W-1:0];
  assign own_req    = req_arr[owner_q];
  assign resp_ready = oresp[0];
  assign resp_last  = oresp[1];

  // State, owner and round-robin pointer registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
    end
  end

  // Arbitration and transaction-end detection; the winner gets the lowest
  // priority next time so continuously-valid requesters never starve
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          owner_d = pick_win;
          rr_d    = (pick_win == IDX_W'(NUM_REQ - 1)) ? '0 : pick_win + 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Owner dropping valid before last is an abort; last ends normally
        if (!own_req[0] || (resp_ready && resp_last)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Combinational data path: owner's request out, memory response back to owner only
  always_comb begin
    oreq   = '0;
    iresps = '0;
    if (state_q == BUSY) begin
      oreq = own_req;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (owner_q == IDX_W'(j)) begin
          iresps[j*RESP_W +: RESP_W] = oresp;
        end
      end
    end
  end

  assign busy  = (state_q == BUSY);
  assign owner = owner_q;

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed bench for cbus_arbiter: a per-cycle vector table for reset,
// single-beat, ready-without-last and round-robin behaviour, followed by
// hand-written sequences for burst, abort and reset mid-burst.
module tb_cbus_arbiter;

  localparam int REQ_W  = 79;
  localparam int RESP_W = 34;

  logic                  clk;
  logic                  reset;
  logic [2*REQ_W-1:0]    ireqs;
  logic [2*RESP_W-1:0]   iresps;
  logic [REQ_W-1:0]      oreq;
  logic [RESP_W-1:0]     oresp;
  logic                  busy;
  logic [0:0]            owner;

  cbus_arbiter #(.NUM_REQ(2)) dut (
    .clk    (clk),
    .reset  (reset),
    .ireqs  (ireqs),
    .iresps (iresps),
    .oreq   (oreq),
    .oresp  (oresp),
    .busy   (busy),
    .owner  (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Request templates (valid bit clear; set per cycle)
  logic [REQ_W-1:0] req0_base;
  logic [REQ_W-1:0] req1_base;
  logic             v0, v1;

  function automatic logic [REQ_W-1:0] mk_req(input logic wr, input logic [2:0] size,
                                              input logic [31:0] addr, input logic [3:0] strb,
                                              input logic [31:0] data, input logic [3:0] len,
                                              input logic [1:0] burst);
    return {burst, len, data, strb, addr, size, wr, 1'b0};
  endfunction

  function automatic logic [REQ_W-1:0] cur_req(input int p);
    if (p == 0) return req0_base | REQ_W'(v0);
    return req1_base | REQ_W'(v1);
  endfunction

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst_n, input logic a0, input logic a1,
                       input logic rdy, input logic lst, input logic [31:0] rdata);
    reset = rst_n;
    v0    = a0;
    v1    = a1;
    ireqs = {cur_req(1), cur_req(0)};
    oresp = {rdata, lst, rdy};
  endtask

  // Check all outputs; sel: 0 = nothing routed, 1 = port 0, 2 = port 1
  task automatic check_all(input string name, input logic e_busy, input logic e_own,
                           input int sel);
    logic [REQ_W-1:0]    e_oreq;
    logic [2*RESP_W-1:0] e_resp;
    e_oreq = '0;
    e_resp = '0;
    if (sel == 1) begin
      e_oreq = cur_req(0);
      e_resp = {{RESP_W{1'b0}}, oresp};
    end else if (sel == 2) begin
      e_oreq = cur_req(1);
      e_resp = {oresp, {RESP_W{1'b0}}};
    end
    check({name, ".status"}, 160'({busy, owner}), 160'({e_busy, e_own}));
    check({name, ".oreq"},   160'(oreq),   160'(e_oreq));
    check({name, ".iresps"}, 160'(iresps), 160'(e_resp));
  endtask

  typedef struct {
    logic        rst_n, a0, a1, rdy, lst;
    logic [31:0] rdata;
    logic        e_busy, e_own;
    int          sel;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst_n, input logic a0, input logic a1, input logic rdy,
                     input logic lst, input logic [31:0] rdata,
                     input logic e_busy, input logic e_own, input int sel);
    vec_t v;
    v.rst_n = rst_n; v.a0 = a0; v.a1 = a1; v.rdy = rdy; v.lst = lst; v.rdata = rdata;
    v.e_busy = e_busy; v.e_own = e_own; v.sel = sel;
    vecs.push_back(v);
  endtask

  // Inputs change on the falling edge; outputs sampled 1 time unit later
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    v0 = 1'b0;
    v1 = 1'b0;
    req0_base = mk_req(1'b0, 3'd2, 32'h0000_1000, 4'h0, 32'h0, 4'd15, 2'd1);
    req1_base = mk_req(1'b0, 3'd2, 32'h4060_0004, 4'h0, 32'h0, 4'd0,  2'd0);
    ireqs = '0;
    oresp = '0;

    // rst, v0, v1, rdy, lst, rdata, busy, owner, sel
    add(0, 1, 0, 0, 0, 32'h0,         0, 0, 0); // in reset with request pending
    add(0, 1, 0, 1, 1, 32'hAAAA_AAAA, 0, 0, 0); // response during reset ignored
    add(1, 1, 0, 0, 0, 32'h0,         0, 0, 0); // reset released, still idle
    add(1, 1, 0, 0, 0, 32'h0,         1, 0, 1); // granted to port 0
    add(1, 1, 0, 1, 1, 32'h0000_0011, 1, 0, 1); // single-beat completion
    add(1, 0, 0, 0, 0, 32'h0,         0, 0, 0); // bubble
    add(1, 0, 1, 0, 0, 32'h0,         0, 0, 0); // port 1 uncached read requested
    add(1, 0, 1, 1, 1, 32'hDEAD_BEEF, 1, 1, 2); // data delivered same cycle
    add(1, 0, 0, 1, 1, 32'h0000_0055, 0, 1, 0); // response while idle not forwarded
    add(1, 1, 1, 0, 0, 32'h0,         0, 1, 0); // both request, rr_ptr=0
    add(1, 1, 1, 1, 1, 32'h1,         1, 0, 1); // grant #1 -> port 0
    add(1, 1, 1, 0, 0, 32'h0,         0, 0, 0);
    add(1, 1, 1, 1, 1, 32'h2,         1, 1, 2); // grant #2 -> port 1
    add(1, 1, 1, 0, 0, 32'h0,         0, 1, 0);
    add(1, 1, 1, 1, 0, 32'h3,         1, 0, 1); // grant #3 -> port 0, ready no last
    add(1, 1, 1, 1, 1, 32'h4,         1, 0, 1);
    add(1, 1, 1, 0, 0, 32'h0,         0, 0, 0);
    add(1, 1, 1, 1, 1, 32'h5,         1, 1, 2); // grant #4 -> port 1
    add(1, 1, 1, 0, 0, 32'h0,         0, 1, 0);
    add(1, 1, 1, 1, 1, 32'h6,         1, 0, 1); // grant #5 -> port 0
    add(1, 1, 1, 0, 0, 32'h0,         0, 0, 0);
    add(1, 1, 1, 1, 1, 32'h7,         1, 1, 2); // grant #6 -> port 1
    add(1, 0, 0, 0, 0, 32'h0,         0, 1, 0);

    step();
    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].a0, vecs[i].a1, vecs[i].rdy, vecs[i].lst, vecs[i].rdata);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].e_busy, vecs[i].e_own, vecs[i].sel);
      step();
    end

    // Burst of 16 beats from port 0; port 1 raises valid mid-burst
    drive(1, 1, 0, 0, 0, 32'h0); #1;
    check_all("burst.req", 0, 1, 0);
    step();
    for (int b = 0; b < 16; b++) begin
      drive(1, 1, (b >= 4), 1, (b == 15), 32'h1000 + b); #1;
      check_all($sformatf("burst.beat%0d", b), 1, 0, 1);
      step();
    end
    drive(1, 0, 1, 0, 0, 32'h0); #1;
    check_all("burst.bubble", 0, 0, 0);
    step();
    drive(1, 0, 1, 1, 1, 32'h2222_0001); #1;
    check_all("burst.p1grant", 1, 1, 2);
    step();
    drive(1, 0, 0, 0, 0, 32'h0); #1;
    check_all("burst.idle", 0, 1, 0);
    step();

    // Abort: port 0 drops valid after 3 of 8 beats, port 1 pending
    req0_base = mk_req(1'b0, 3'd2, 32'h0000_2000, 4'h0, 32'h0, 4'd7, 2'd1);
    drive(1, 1, 1, 0, 0, 32'h0); #1;
    check_all("abort.req", 0, 1, 0);
    step();
    for (int b = 0; b < 3; b++) begin
      drive(1, 1, 1, 1, 0, 32'h3000 + b); #1;
      check_all($sformatf("abort.beat%0d", b), 1, 0, 1);
      step();
    end
    drive(1, 0, 1, 0, 0, 32'h0); #1;
    check_all("abort.drop", 1, 0, 1);
    check("abort.oreq_valid", 160'(oreq[0]), 160'(0));
    step();
    drive(1, 0, 1, 0, 0, 32'h0); #1;
    check_all("abort.idle", 0, 0, 0);
    step();
    drive(1, 0, 1, 1, 1, 32'h4444_0001); #1;
    check_all("abort.p1grant", 1, 1, 2);
    step();
    drive(1, 0, 0, 0, 0, 32'h0); #1;
    check_all("abort.end", 0, 1, 0);
    step();

    // Reset during beat 5 of an 8-beat DCache writeback on port 1
    req1_base = mk_req(1'b1, 3'd2, 32'h0000_8000, 4'hF, 32'hCAFE_F00D, 4'd7, 2'd1);
    drive(1, 0, 1, 0, 0, 32'h0); #1;
    check_all("wb.req", 0, 1, 0);
    step();
    for (int b = 0; b < 4; b++) begin
      drive(1, 0, 1, 1, 0, 32'h5000 + b); #1;
      check_all($sformatf("wb.beat%0d", b), 1, 1, 2);
      step();
    end
    drive(0, 0, 1, 1, 0, 32'h5004); #1;
    check_all("wb.reset", 0, 0, 0);
    step();
    drive(0, 1, 1, 1, 0, 32'h0); #1;
    check_all("wb.reset_hold", 0, 0, 0);
    step();
    drive(1, 1, 1, 0, 0, 32'h0); #1;
    check_all("wb.release", 0, 0, 0);
    step();
    drive(1, 1, 1, 0, 0, 32'h0); #1;
    check_all("wb.rr_after_reset", 1, 0, 1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Absolute time bound so the bench always terminates
  initial begin
    #100000;
    $display("FAIL timeout: simulation time bound reached, expected completion");
    $fatal(1);
  end

endmodule
